result_writeback_buffer: RTL and testbench

- Output-side counterpart of the input memory buffer: collects N-wide result row vectors drained from the sum-stationary processor array and writes them back to memory, PARALLEL_DATA_STREAMING_SIZE values per beat.
- Instructed by the controller with a destination base address, row stride and row count.
- Raises a one-cycle done pulse when the whole tile has been written.

---
 rtl/result_writeback_buffer.sv | 204 ++++++++++++++++++++
 tb/tb_result_writeback_buffer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_writeback_buffer.sv
// result_writeback_buffer
// Collects up to N result row vectors from the processor array, then writes
// them to memory P elements per beat at base + row*stride + chunk*P.
// Emits a one-cycle done pulse after the final beat of the tile.
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   instruction_*          controller command (address, stride, rows); ready only in IDLE
//   result_*               processor result vectors (valid/ready, data, last)
//   memory_write_*         write beats (valid/ready, address, data)
//   done                   one-cycle tile completion pulse
//   protocol_error         sticky flag for result_last misalignment
module result_writeback_buffer #(
  parameter int unsigned DATA_WIDTH                   = 32,
  parameter int unsigned N                            = 4,
  parameter int unsigned PARALLEL_DATA_STREAMING_SIZE = 2,
  parameter int unsigned MEMORY_ADDRESS_BITS          = 64,
  parameter int unsigned ROW_BITS                     = $clog2(N + 1)
) (
  input  logic                                               clk,
  input  logic                                               reset,
  input  logic                                               instruction_valid,
  output logic                                               instruction_ready,
  input  logic [MEMORY_ADDRESS_BITS-1:0]                     address_input,
  input  logic [MEMORY_ADDRESS_BITS-1:0]                     stride_input,
  input  logic [ROW_BITS-1:0]                                rows_input,
  input  logic                                               result_valid,
  output logic                                               result_ready,
  input  logic [DATA_WIDTH*N-1:0]                            result_data,
  input  logic                                               result_last,
  output logic                                               memory_write_valid,
  input  logic                                               memory_write_ready,
  output logic [MEMORY_ADDRESS_BITS-1:0]                     memory_address,
  output logic [DATA_WIDTH*PARALLEL_DATA_STREAMING_SIZE-1:0] memory_write_data,
  output logic                                               done,
  output logic                                               protocol_error
);

  localparam int unsigned P          = PARALLEL_DATA_STREAMING_SIZE;
  localparam int unsigned CHUNKS     = N / P;
  localparam int unsigned CHUNK_BITS = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int unsigned IDX_BITS   = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned ROW_W      = DATA_WIDTH * N;
  localparam int unsigned BEAT_W     = DATA_WIDTH * P;
  localparam int unsigned AW         = MEMORY_ADDRESS_BITS;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [ROW_BITS-1:0]   r_row_cnt;
  logic [ROW_BITS-1:0]   w_row_cnt_nxt;
  logic [CHUNK_BITS-1:0] r_chunk_cnt;
  logic [CHUNK_BITS-1:0] w_chunk_cnt_nxt;
  logic [AW-1:0]         r_row_addr;
  logic [AW-1:0]         w_row_addr_nxt;
  logic [AW-1:0]         r_stride;
  logic [ROW_BITS-1:0]   r_rows;
  logic [ROW_W-1:0]      r_buf [N];

  logic                  r_instruction_ready;
  logic                  r_result_ready;
  logic                  r_mem_valid;
  logic [AW-1:0]         r_mem_addr;
  logic [BEAT_W-1:0]     r_mem_data;
  logic                  r_done;
  logic                  r_protocol_error;

  logic                  w_instr_hs;
  logic                  w_res_hs;
  logic                  w_last_row;
  logic                  w_last_chunk;
  logic                  w_load_beat;
  logic                  w_beat_from_input;
  logic [ROW_W-1:0]      w_src_row;
  logic [BEAT_W-1:0]     w_beat_data;
  logic [AW-1:0]         w_beat_addr;

  // Handshakes are qualified by state; the ready outputs are decodes of it.
  assign w_instr_hs   = (r_state == S_IDLE) && instruction_valid;
  assign w_res_hs     = (r_state == S_RECV) && result_valid;
  assign w_last_row   = (r_row_cnt == (r_rows - ROW_BITS'(1)));
  assign w_last_chunk = (r_chunk_cnt == CHUNK_BITS'(CHUNKS - 1));

  // Next-state, counter and beat-load decisions.
  always_comb begin
    w_state_nxt       = r_state;
    w_row_cnt_nxt     = r_row_cnt;
    w_chunk_cnt_nxt   = r_chunk_cnt;
    w_row_addr_nxt    = r_row_addr;
    w_load_beat       = 1'b0;
    w_beat_from_input = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (instruction_valid) begin
          w_state_nxt     = (rows_input != '0) ? S_RECV : S_DONE;
          w_row_cnt_nxt   = '0;
          w_chunk_cnt_nxt = '0;
          w_row_addr_nxt  = address_input;
        end
      end
      S_RECV: begin
        if (result_valid) begin
          if (w_last_row) begin
            w_state_nxt       = S_WRITE;
            w_row_cnt_nxt     = '0;
            w_chunk_cnt_nxt   = '0;
            w_load_beat       = 1'b1;
            // With a single row, row 0 is still on the input this cycle.
            w_beat_from_input = (r_row_cnt == '0);
          end else begin
            w_row_cnt_nxt = r_row_cnt + ROW_BITS'(1);
          end
        end
      end
      S_WRITE: begin
        if (memory_write_ready) begin
          if (w_last_chunk) begin
            w_chunk_cnt_nxt = '0;
            w_row_cnt_nxt   = r_row_cnt + ROW_BITS'(1);
            w_row_addr_nxt  = r_row_addr + r_stride;
            if (w_last_row) begin
              w_state_nxt = S_DONE;
            end else begin
              w_load_beat = 1'b1;
            end
          end else begin
            w_chunk_cnt_nxt = r_chunk_cnt + CHUNK_BITS'(1);
            w_load_beat     = 1'b1;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Beat that becomes visible once the next state settles.
  assign w_src_row   = w_beat_from_input ? result_data : r_buf[IDX_BITS'(w_row_cnt_nxt)];
  assign w_beat_data = w_src_row[int'(w_chunk_cnt_nxt) * BEAT_W +: BEAT_W];
  assign w_beat_addr = w_row_addr_nxt + AW'(w_chunk_cnt_nxt) * AW'(P);

  // State register plus registered control outputs decoded from next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state             <= S_IDLE;
      r_row_cnt           <= '0;
      r_chunk_cnt         <= '0;
      r_instruction_ready <= 1'b1;
      r_result_ready      <= 1'b0;
      r_mem_valid         <= 1'b0;
      r_done              <= 1'b0;
      r_protocol_error    <= 1'b0;
    end else begin
      r_state             <= w_state_nxt;
      r_row_cnt           <= w_row_cnt_nxt;
      r_chunk_cnt         <= w_chunk_cnt_nxt;
      r_instruction_ready <= (w_state_nxt == S_IDLE);
      r_result_ready      <= (w_state_nxt == S_RECV);
      r_mem_valid         <= (w_state_nxt == S_WRITE);
      r_done              <= (w_state_nxt == S_DONE);
      if (w_instr_hs) begin
        r_protocol_error <= 1'b0;
      end else if (w_res_hs && (result_last != w_last_row)) begin
        r_protocol_error <= 1'b1;
      end
    end
  end

  // Datapath registers; contents need no reset.
  always_ff @(posedge clk) begin
    r_row_addr <= w_row_addr_nxt;
    if (w_instr_hs) begin
      r_stride <= stride_input;
      r_rows   <= rows_input;
    end
    if (w_res_hs) begin
      r_buf[IDX_BITS'(r_row_cnt)] <= result_data;
    end
    if (w_load_beat) begin
      r_mem_addr <= w_beat_addr;
      r_mem_data <= w_beat_data;
    end
  end

  assign instruction_ready  = r_instruction_ready;
  assign result_ready       = r_result_ready;
  assign memory_write_valid = r_mem_valid;
  assign memory_address     = r_mem_addr;
  assign memory_write_data  = r_mem_data;
  assign done               = r_done;
  assign protocol_error     = r_protocol_error;

endmodule

// File: tb/tb_result_writeback_buffer.sv
// Directed bench for result_writeback_buffer (N=4, P=2, 32-bit data, 64-bit addresses).
module tb_result_writeback_buffer;

  localparam int DW = 32;
  localparam int N  = 4;
  localparam int P  = 2;
  localparam int AW = 64;
  localparam int RB = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              instruction_valid;
  logic              instruction_ready;
  logic [AW-1:0]     address_input;
  logic [AW-1:0]     stride_input;
  logic [RB-1:0]     rows_input;
  logic              result_valid;
  logic              result_ready;
  logic [DW*N-1:0]   result_data;
  logic              result_last;
  logic              memory_write_valid;
  logic              memory_write_ready;
  logic [AW-1:0]     memory_address;
  logic [DW*P-1:0]   memory_write_data;
  logic              done;
  logic              protocol_error;

  result_writeback_buffer #(
    .DATA_WIDTH(DW), .N(N), .PARALLEL_DATA_STREAMING_SIZE(P),
    .MEMORY_ADDRESS_BITS(AW), .ROW_BITS(RB)
  ) dut (
    .clk(clk), .reset(reset),
    .instruction_valid(instruction_valid), .instruction_ready(instruction_ready),
    .address_input(address_input), .stride_input(stride_input), .rows_input(rows_input),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_data(result_data), .result_last(result_last),
    .memory_write_valid(memory_write_valid), .memory_write_ready(memory_write_ready),
    .memory_address(memory_address), .memory_write_data(memory_write_data),
    .done(done), .protocol_error(protocol_error)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observation log, sampled mid-cycle.
  logic [AW-1:0]   beat_addr_q[$];
  logic [DW*P-1:0] beat_data_q[$];
  logic [AW-1:0]   stall_addr_q[$];
  logic [DW*P-1:0] stall_data_q[$];
  int   res_cnt, instr_cnt, done_cnt, instr_cyc, done_cyc, rr_high_cnt;
  logic ir_at_done, ir_after_done, prev_done;

  always @(negedge clk) begin
    if (instruction_valid && instruction_ready) begin instr_cnt++; instr_cyc = cyc; end
    if (result_valid && result_ready) res_cnt++;
    if (result_ready) rr_high_cnt++;
    if (memory_write_valid && memory_write_ready) begin
      beat_addr_q.push_back(memory_address);
      beat_data_q.push_back(memory_write_data);
    end
    if (memory_write_valid && !memory_write_ready) begin
      stall_addr_q.push_back(memory_address);
      stall_data_q.push_back(memory_write_data);
    end
    if (prev_done) ir_after_done = instruction_ready;
    if (done) begin done_cnt++; done_cyc = cyc; ir_at_done = instruction_ready; end
    prev_done = done;
  end

  task automatic clear_mon();
    beat_addr_q.delete(); beat_data_q.delete();
    stall_addr_q.delete(); stall_data_q.delete();
    res_cnt = 0; instr_cnt = 0; done_cnt = 0; instr_cyc = 0; done_cyc = 0;
    rr_high_cnt = 0; ir_at_done = 1'bx; ir_after_done = 1'bx; prev_done = 1'b0;
  endtask

  function automatic logic [DW*N-1:0] row_vec(input int i);
    logic [DW*N-1:0] v;
    for (int k = 0; k < N; k++) v[k*DW +: DW] = DW'(4 * i + k);
    return v;
  endfunction

  function automatic logic [DW*P-1:0] beat_val(input int lo);
    return {DW'(lo + 1), DW'(lo)};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Drives one tile: instruction, R result vectors, then memory ready with an
  // optional stall on one beat or a reset after a given number of beats.
  task automatic run_tile(input logic [AW-1:0] addr, input logic [AW-1:0] stride,
                          input int rows, input logic [N-1:0] last_mask,
                          input int stall_beat, input int stall_len,
                          input bit hold, input int abort_after);
    int n;
    int stalls;
    int start_done;
    start_done  = done_cnt;
    result_data = row_vec(0);
    result_last = last_mask[0];
    if (hold) begin
      result_valid = 1'b1;
      repeat (3) tick();
    end
    address_input     = addr;
    stride_input      = stride;
    rows_input        = RB'(rows);
    instruction_valid = 1'b1;
    n = 0;
    while (!instruction_ready && n < 20) begin tick(); n++; end
    if (n >= 20) begin
      vectors++; miscompares++;
      $display("FAIL instr_timeout: instruction_ready stayed %b, required 1", instruction_ready);
    end
    tick();
    if (!hold) instruction_valid = 1'b0;
    for (int i = 0; i < rows; i++) begin
      result_data  = row_vec(i);
      result_last  = last_mask[i];
      result_valid = 1'b1;
      n = 0;
      while (!result_ready && n < 20) begin tick(); n++; end
      if (n >= 20) begin
        vectors++; miscompares++;
        $display("FAIL result_timeout: row %0d result_ready=%b, required 1", i, result_ready);
      end
      tick();
    end
    if (!hold) result_valid = 1'b0;
    instruction_valid = 1'b0;
    stalls = 0;
    n = 0;
    while (done_cnt == start_done && n < 100) begin
      if (abort_after >= 0 && beat_addr_q.size() == abort_after) begin
        memory_write_ready = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        return;
      end
      if (beat_addr_q.size() == stall_beat && stalls < stall_len) begin
        memory_write_ready = 1'b0;
        stalls++;
      end else begin
        memory_write_ready = 1'b1;
      end
      tick();
      n++;
    end
    if (n >= 100) begin
      vectors++; miscompares++;
      $display("FAIL done_timeout: done count %0d, required %0d", done_cnt, start_done + 1);
    end
    memory_write_ready = 1'b0;
    result_valid       = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    vectors++; if (instruction_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ir: got %b want 1", instruction_ready); end
    vectors++; if (result_ready !== 1'b0) begin miscompares++; $display("FAIL rst_rr: got %b want 0", result_ready); end
    vectors++; if (memory_write_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mwv: got %b want 0", memory_write_valid); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %b want 0", done); end
    vectors++; if (protocol_error !== 1'b0) begin miscompares++; $display("FAIL rst_perr: got %b want 0", protocol_error); end
  endtask

  // Expected beats for base 0x100, stride 16, R=4.
  logic [AW-1:0]   exp_addr [8] = '{64'h100, 64'h102, 64'h110, 64'h112, 64'h120, 64'h122, 64'h130, 64'h132};
  logic [DW*P-1:0] exp_data [8] = '{{32'd1, 32'd0}, {32'd3, 32'd2}, {32'd5, 32'd4}, {32'd7, 32'd6},
                                    {32'd9, 32'd8}, {32'd11, 32'd10}, {32'd13, 32'd12}, {32'd15, 32'd14}};

  task automatic test_full_tile();
    clear_mon();
    run_tile(64'h100, 64'd16, 4, 4'b1000, -1, 0, 1'b0, -1);
    vectors++; if (beat_addr_q.size() !== 8) begin miscompares++; $display("FAIL full_beats: got %0d want 8", beat_addr_q.size()); end
    for (int i = 0; i < 8 && i < beat_addr_q.size(); i++) begin
      vectors++;
      if (beat_addr_q[i] !== exp_addr[i] || beat_data_q[i] !== exp_data[i]) begin
        miscompares++;
        $display("FAIL full_beat%0d: got %h/%h want %h/%h", i, beat_addr_q[i], beat_data_q[i], exp_addr[i], exp_data[i]);
      end
    end
    vectors++; if (done_cyc - instr_cyc !== 13) begin miscompares++; $display("FAIL full_latency: got %0d want 13", done_cyc - instr_cyc); end
    vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL full_done: got %0d want 1", done_cnt); end
    vectors++; if (res_cnt !== 4) begin miscompares++; $display("FAIL full_results: got %0d want 4", res_cnt); end
    vectors++; if (protocol_error !== 1'b0) begin miscompares++; $display("FAIL full_perr: got %b want 0", protocol_error); end
  endtask

  task automatic test_backpressure();
    clear_mon();
    run_tile(64'h100, 64'd16, 4, 4'b1000, 2, 3, 1'b0, -1);
    vectors++; if (beat_addr_q.size() !== 8) begin miscompares++; $display("FAIL bp_beats: got %0d want 8", beat_addr_q.size()); end
    for (int i = 0; i < 8 && i < beat_addr_q.size(); i++) begin
      vectors++;
      if (beat_addr_q[i] !== exp_addr[i] || beat_data_q[i] !== exp_data[i]) begin
        miscompares++;
        $display("FAIL bp_beat%0d: got %h/%h want %h/%h", i, beat_addr_q[i], beat_data_q[i], exp_addr[i], exp_data[i]);
      end
    end
    vectors++; if (stall_addr_q.size() !== 3) begin miscompares++; $display("FAIL bp_stall_cycles: got %0d want 3", stall_addr_q.size()); end
    for (int i = 0; i < stall_addr_q.size(); i++) begin
      vectors++;
      if (stall_addr_q[i] !== 64'h110 || stall_data_q[i] !== beat_val(4)) begin
        miscompares++;
        $display("FAIL bp_hold%0d: got %h/%h want 110/%h", i, stall_addr_q[i], stall_data_q[i], beat_val(4));
      end
    end
    vectors++; if (done_cyc - instr_cyc !== 16) begin miscompares++; $display("FAIL bp_latency: got %0d want 16", done_cyc - instr_cyc); end
  endtask

  task automatic test_zero_rows();
    clear_mon();
    run_tile(64'h200, 64'd8, 0, 4'b0000, -1, 0, 1'b0, -1);
    vectors++; if (rr_high_cnt !== 0) begin miscompares++; $display("FAIL zero_rr: got %0d cycles want 0", rr_high_cnt); end
    vectors++; if (beat_addr_q.size() !== 0) begin miscompares++; $display("FAIL zero_beats: got %0d want 0", beat_addr_q.size()); end
    vectors++; if (done_cyc - instr_cyc !== 1) begin miscompares++; $display("FAIL zero_latency: got %0d want 1", done_cyc - instr_cyc); end
    vectors++; if (ir_at_done !== 1'b0) begin miscompares++; $display("FAIL zero_ir_done: got %b want 0", ir_at_done); end
    vectors++; if (ir_after_done !== 1'b1) begin miscompares++; $display("FAIL zero_ir_after: got %b want 1", ir_after_done); end
  endtask

  task automatic test_protocol_error();
    clear_mon();
    run_tile(64'h300, 64'd4, 2, 4'b0001, -1, 0, 1'b0, -1);
    repeat (3) tick();
    vectors++; if (protocol_error !== 1'b1) begin miscompares++; $display("FAIL perr_sticky: got %b want 1", protocol_error); end
    vectors++; if (res_cnt !== 2) begin miscompares++; $display("FAIL perr_results: got %0d want 2", res_cnt); end
    vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL perr_done: got %0d want 1", done_cnt); end
    vectors++; if (beat_addr_q.size() !== 4) begin miscompares++; $display("FAIL perr_beats: got %0d want 4", beat_addr_q.size()); end
    for (int i = 0; i < 4 && i < beat_addr_q.size(); i++) begin
      vectors++;
      if (beat_addr_q[i] !== 64'h300 + AW'(4 * (i / 2) + 2 * (i % 2)) || beat_data_q[i] !== beat_val(2 * i)) begin
        miscompares++;
        $display("FAIL perr_beat%0d: got %h/%h want %h/%h", i, beat_addr_q[i], beat_data_q[i],
                 64'h300 + AW'(4 * (i / 2) + 2 * (i % 2)), beat_val(2 * i));
      end
    end
  endtask

  task automatic test_reset_abort();
    clear_mon();
    run_tile(64'h100, 64'd16, 4, 4'b1000, -1, 0, 1'b0, 3);
    vectors++; if (memory_write_valid !== 1'b0) begin miscompares++; $display("FAIL abort_mwv: got %b want 0", memory_write_valid); end
    vectors++; if (instruction_ready !== 1'b1) begin miscompares++; $display("FAIL abort_ir: got %b want 1", instruction_ready); end
    repeat (5) tick();
    vectors++; if (done_cnt !== 0) begin miscompares++; $display("FAIL abort_done: got %0d want 0", done_cnt); end
    vectors++; if (beat_addr_q.size() !== 3) begin miscompares++; $display("FAIL abort_beats: got %0d want 3", beat_addr_q.size()); end
    clear_mon();
    run_tile(64'h40, 64'd8, 1, 4'b0001, -1, 0, 1'b0, -1);
    vectors++; if (beat_addr_q.size() !== 2) begin miscompares++; $display("FAIL after_beats: got %0d want 2", beat_addr_q.size()); end
    for (int i = 0; i < 2 && i < beat_addr_q.size(); i++) begin
      vectors++;
      if (beat_addr_q[i] !== 64'h40 + AW'(2 * i) || beat_data_q[i] !== beat_val(2 * i)) begin
        miscompares++;
        $display("FAIL after_beat%0d: got %h/%h want %h/%h", i, beat_addr_q[i], beat_data_q[i], 64'h40 + AW'(2 * i), beat_val(2 * i));
      end
    end
    vectors++; if (done_cyc - instr_cyc !== 4) begin miscompares++; $display("FAIL after_latency: got %0d want 4", done_cyc - instr_cyc); end
    vectors++; if (protocol_error !== 1'b0) begin miscompares++; $display("FAIL after_perr: got %b want 0", protocol_error); end
  endtask

  task automatic test_held_valids();
    clear_mon();
    run_tile(64'h500, 64'd32, 2, 4'b0010, -1, 0, 1'b1, -1);
    repeat (3) tick();
    vectors++; if (instr_cnt !== 1) begin miscompares++; $display("FAIL hold_instr: got %0d want 1", instr_cnt); end
    vectors++; if (res_cnt !== 2) begin miscompares++; $display("FAIL hold_results: got %0d want 2", res_cnt); end
    vectors++; if (beat_addr_q.size() !== 4) begin miscompares++; $display("FAIL hold_beats: got %0d want 4", beat_addr_q.size()); end
    for (int i = 0; i < 4 && i < beat_addr_q.size(); i++) begin
      vectors++;
      if (beat_addr_q[i] !== 64'h500 + AW'(32 * (i / 2) + 2 * (i % 2)) || beat_data_q[i] !== beat_val(2 * i)) begin
        miscompares++;
        $display("FAIL hold_beat%0d: got %h/%h want %h/%h", i, beat_addr_q[i], beat_data_q[i],
                 64'h500 + AW'(32 * (i / 2) + 2 * (i % 2)), beat_val(2 * i));
      end
    end
    vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL hold_done: got %0d want 1", done_cnt); end
    vectors++; if (protocol_error !== 1'b0) begin miscompares++; $display("FAIL hold_perr: got %b want 0", protocol_error); end
  endtask

  initial begin
    reset              = 1'b1;
    instruction_valid  = 1'b0;
    address_input      = '0;
    stride_input       = '0;
    rows_input         = '0;
    result_valid       = 1'b0;
    result_data        = '0;
    result_last        = 1'b0;
    memory_write_ready = 1'b0;
    clear_mon();
    test_reset();
    test_full_tile();
    test_backpressure();
    test_zero_rows();
    test_protocol_error();
    test_reset_abort();
    test_held_valids();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
